multicycle_control_seq: RTL and testbench
=========================================

# multicycle_control_seq

Parametrised multi-cycle control sequencer, the successor to the single-cycle control ROM. It accepts a one-hot decoded opcode through a valid/ready handshake and steps it through DECODE, EXEC, MEM and WB states. In each state it drives a registered 7-bit control word. It sits between the instruction decoder and the datapath, and allows the datapath to share the ALU and memory port across cycles.

## Interface
Parameters:
- OPC_W, 64: width of the one-hot opcode bus.
- ADD_BIT, 4: opcode bit position for ADD.
- AND_BIT, 25: opcode bit position for AND.
- MOVL_BIT, 11: opcode bit position for MOVL (load).
- MOVS_BIT, 13: opcode bit position for MOVS (store).
- JA_BIT, 14: opcode bit position for JA.
- CMP_BIT, 59: opcode bit position for CMP.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- opc, in, OPC_W: one-hot decoded opcode; sampled only on accept.
- opc_valid, in, 1: opcode offered.
- opc_ready, out, 1: sequencer idle and able to accept.
- stall, in, 1: freezes the sequencer when high.
- ctrl, out, 7: registered control word, fields {reg_write, alu_src, alu_op[1:0], mem_read, mem_write, mem_to_reg}.
- done, out, 1: one-cycle pulse in the final state of an instruction.
- illegal, out, 1: illegal-opcode indication (see Configuration).

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB, plus TRAP when the trap feature is compiled in.
- IDLE:
  - opc_ready = !stall.
  - Accept condition is opc_valid && opc_ready; opc is latched into opc_q and the next state is DECODE.
- DECODE:
  - Classifies opc_q. Legal means exactly one bit set, and that bit is one of the six configured positions.
  - Legal -> EXEC. Illegal -> handled as described under Configuration.
- EXEC control word per opcode:
  - ADD: alu_op=00, alu_src=0.
  - AND: alu_op=01, alu_src=0.
  - MOVL and MOVS: alu_op=00, alu_src=1.
  - CMP: alu_op=10.
  - JA: alu_op=11.
- Transition out of EXEC:
  - MOVL, MOVS -> MEM.
  - ADD, AND -> WB.
  - CMP, JA -> IDLE, with done asserted in EXEC.
- MEM:
  - MOVL: mem_read=1, next state WB.
  - MOVS: mem_write=1, done asserted, next state IDLE.
- WB:
  - reg_write=1 for all instructions that reach WB.
  - mem_to_reg=1 for MOVL only.
  - done asserted; next state IDLE.
- ctrl is all-zero in IDLE and DECODE. Every field not listed for the current state is 0; the sequencer never drives X.
- Latched opcode:
  - opc_q holds its value from accept until the next accept.
  - Changes on opc while the sequencer is busy have no effect.

## Timing
- Reset values: state=IDLE, ctrl=7'b0, done=0, illegal=0, opc_q=0. opc_ready follows !stall in the first cycle after reset.
- ctrl and done are registered and reflect the current state.
- Latency counts cycles from the accept edge to the done cycle, inclusive:
  - CMP, JA: 2.
  - ADD, AND, MOVS: 3.
  - MOVL: 4.
- Throughput: the cycle after done is IDLE, so the next accept happens no earlier than one cycle after done.
- stall=1 in any state:
  - State, ctrl and opc_q hold.
  - done is held high if the sequencer is stalled in a done cycle. The datapath qualifies done with !stall.
- Reset asserted mid-instruction: outputs clear immediately and asynchronously. The in-flight instruction is discarded and no done is issued for it.
- opc_valid is ignored outside IDLE.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE -> TRAP. illegal is set sticky and ctrl stays 0.
  - opc_ready=0 until rst_n is asserted.
- CTRL_ILLEGAL_TRAP_EN undefined:
  - An illegal opcode -> IDLE, with done=1 and illegal=1 for that single cycle.
  - The instruction acts as a NOP with ctrl=0.
- The TRAP state and sticky logic are absent from the netlist when the macro is undefined.

## Structure
- Shared package `ctrl_pkg`:
  - state enum.
  - control-word field indices and widths.
  - alu_op encodings: ALU_ADD=2'b00, ALU_AND=2'b01, ALU_CMP=2'b10, ALU_JA=2'b11.
- Sub-module `opc_classify` (combinational):
  - Inputs: opc_q.
  - Outputs: a 6-bit instruction one-hot and an illegal flag.
  - Checks exact one-hotness with a popcount == 1 test.
- Top-level: state register, next-state logic, ctrl/done registers.

## Test plan
- Reset, then ADD with opc=1<<4, valid for 1 cycle:
  - opc_ready=1 before accept.
  - EXEC ctrl=7'b0000000, then WB ctrl=7'b1000000 with done=1.
  - Done cycle is 3 cycles after accept.
- MOVL (1<<11):
  - EXEC 7'b0100000, MEM 7'b0000100, WB 7'b1000001 with done=1.
  - Latency 4.
- MOVS (1<<13): EXEC 7'b0100000, then MEM 7'b0000010 with done=1.
- CMP (1<<59) with stall=1 held for 3 cycles in EXEC:
  - ctrl holds 7'b0010000 throughout the stall.
  - done=1 until stall drops; next cycle is IDLE.
- Illegal opcode opc=(1<<4)|(1<<25):
  - With the macro defined: TRAP, illegal stays 1, opc_ready=0 for 10 cycles, and rst_n clears it.
  - Without the macro: done=1 and illegal=1 for one cycle, then IDLE.
- rst_n pulsed low during the MEM cycle of MOVL:
  - ctrl=0 immediately, no done.
  - Next ADD runs normally.

Source files
------------

// File: rtl/multicycle_control_seq_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg: shared definitions for the multi-cycle control sequencer.
//
// Contents:
//   - state_e      : sequencer state enum. The TRAP state exists only when
//                    CTRL_ILLEGAL_TRAP_EN is defined.
//   - CTRL_*       : bit positions and widths of the 7-bit control word
//                    {reg_write, alu_src, alu_op[1:0], mem_read, mem_write,
//                    mem_to_reg}.
//   - ALU_*        : alu_op encodings.
//   - I_*          : positions inside the 6-bit instruction one-hot produced
//                    by opc_classify.
//   - exec_word / mem_word / wb_word : control word driven in each state.
//
// Configuration macro: CTRL_ILLEGAL_TRAP_EN
// -----------------------------------------------------------------------------
package ctrl_pkg;

    localparam int CTRL_W          = 7;
    localparam int CTRL_REG_WRITE  = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_ALU_OP_LSB = 3;
    localparam int CTRL_ALU_OP_W   = 2;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    localparam logic [CTRL_ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_AND = 2'b01;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_CMP = 2'b10;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_JA  = 2'b11;

    localparam int INST_W = 6;
    localparam int I_ADD  = 0;
    localparam int I_AND  = 1;
    localparam int I_MOVL = 2;
    localparam int I_MOVS = 3;
    localparam int I_JA   = 4;
    localparam int I_CMP  = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,S_TRAP  = 3'd5
`endif
    } state_e;

    // Control word for the EXEC state. ADD leaves alu_op at ALU_ADD (zero).
    function automatic logic [CTRL_W-1:0] exec_word(input logic [INST_W-1:0] inst);
        logic [CTRL_W-1:0] w;
        w = '0;
        if (inst[I_AND]) w[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W] = ALU_AND;
        if (inst[I_CMP]) w[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W] = ALU_CMP;
        if (inst[I_JA])  w[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W] = ALU_JA;
        if (inst[I_MOVL] || inst[I_MOVS]) w[CTRL_ALU_SRC] = 1'b1;
        return w;
    endfunction

    // Control word for the MEM state (loads read, stores write).
    function automatic logic [CTRL_W-1:0] mem_word(input logic [INST_W-1:0] inst);
        logic [CTRL_W-1:0] w;
        w = '0;
        w[CTRL_MEM_READ]  = inst[I_MOVL];
        w[CTRL_MEM_WRITE] = inst[I_MOVS];
        return w;
    endfunction

    // Control word for the WB state; only loads take the result from memory.
    function automatic logic [CTRL_W-1:0] wb_word(input logic [INST_W-1:0] inst);
        logic [CTRL_W-1:0] w;
        w = '0;
        w[CTRL_REG_WRITE]  = 1'b1;
        w[CTRL_MEM_TO_REG] = inst[I_MOVL];
        return w;
    endfunction

endpackage

// File: rtl/multicycle_control_seq_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_seq_if: bundle between the instruction decoder/datapath
// and the control sequencer.
//
// Signals:
//   opc[OPC_W]  : one-hot decoded opcode (decoder -> sequencer)
//   opc_valid   : opcode offered (decoder -> sequencer)
//   opc_ready   : sequencer idle and able to accept (sequencer -> decoder)
//   stall       : freeze request (datapath -> sequencer)
//   ctrl[7]     : registered control word (sequencer -> datapath)
//   done        : final-state pulse (sequencer -> datapath)
//   illegal     : illegal-opcode indication (sequencer -> datapath)
//
// Handshake: an opcode transfers on a rising clk edge where opc_valid and
// opc_ready are both high. opc_ready is only high in IDLE with stall low, and
// opc/opc_valid are ignored on every other cycle.
//
// Modports: master = decoder/datapath side, slave = sequencer.
// -----------------------------------------------------------------------------
interface multicycle_control_seq_if
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 64
);
    logic [OPC_W-1:0]  opc;
    logic              opc_valid;
    logic              opc_ready;
    logic              stall;
    logic [CTRL_W-1:0] ctrl;
    logic              done;
    logic              illegal;

    modport master (
        output opc, opc_valid, stall,
        input  opc_ready, ctrl, done, illegal
    );

    modport slave (
        input  opc, opc_valid, stall,
        output opc_ready, ctrl, done, illegal
    );
endinterface

// File: rtl/multicycle_control_seq_opc_classify.sv
// -----------------------------------------------------------------------------
// opc_classify: combinational classifier for the latched one-hot opcode.
//
// Ports:
//   opc_q_i[OPC_W]  : latched opcode
//   inst_o[6]       : instruction one-hot, index per ctrl_pkg I_* (all zero
//                     when illegal)
//   illegal_o       : opcode is not exactly one of the six configured bits
//
// Legal means the popcount is exactly one AND the set bit is one of the six
// configured positions; anything else (zero, multi-hot, unknown bit) is illegal.
// -----------------------------------------------------------------------------
module opc_classify
    import ctrl_pkg::*;
#(
    parameter int OPC_W    = 64,
    parameter int ADD_BIT  = 4,
    parameter int AND_BIT  = 25,
    parameter int MOVL_BIT = 11,
    parameter int MOVS_BIT = 13,
    parameter int JA_BIT   = 14,
    parameter int CMP_BIT  = 59
) (
    input  logic [OPC_W-1:0]  opc_q_i,
    output logic [INST_W-1:0] inst_o,
    output logic              illegal_o
);
    localparam int CNT_W = $clog2(OPC_W + 1);

    logic [CNT_W-1:0]  ones;
    logic [INST_W-1:0] hits;
    logic              legal;

    always_comb begin
        ones = '0;
        for (int i = 0; i < OPC_W; i++) begin
            ones = ones + CNT_W'(opc_q_i[i]);
        end
    end

    always_comb begin
        hits         = '0;
        hits[I_ADD]  = opc_q_i[ADD_BIT];
        hits[I_AND]  = opc_q_i[AND_BIT];
        hits[I_MOVL] = opc_q_i[MOVL_BIT];
        hits[I_MOVS] = opc_q_i[MOVS_BIT];
        hits[I_JA]   = opc_q_i[JA_BIT];
        hits[I_CMP]  = opc_q_i[CMP_BIT];
    end

    assign legal     = (ones == CNT_W'(1)) && (|hits);
    assign inst_o    = legal ? hits : '0;
    assign illegal_o = !legal;

endmodule

// File: rtl/multicycle_control_seq.sv
// -----------------------------------------------------------------------------
// multicycle_control_seq: multi-cycle control sequencer. Accepts a one-hot
// opcode and steps it through DECODE, EXEC, MEM and WB, driving a registered
// 7-bit control word so the datapath can share the ALU and memory port.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : multicycle_control_seq_if.slave (opc, opc_valid, opc_ready,
//              stall, ctrl, done, illegal)
//   state_o  : current sequencer state (debug visibility)
//
// Configuration macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : illegal opcode parks in TRAP, illegal is sticky, opc_ready
//               stays low until reset.
//   undefined : illegal opcode returns to IDLE with done=1/illegal=1 for one
//               cycle and acts as a NOP.
//
// Cycles from accept edge to done cycle: CMP/JA 2, ADD/AND/MOVS 3, MOVL 4.
// -----------------------------------------------------------------------------
module multicycle_control_seq
    import ctrl_pkg::*;
#(
    parameter int OPC_W    = 64,
    parameter int ADD_BIT  = 4,
    parameter int AND_BIT  = 25,
    parameter int MOVL_BIT = 11,
    parameter int MOVS_BIT = 13,
    parameter int JA_BIT   = 14,
    parameter int CMP_BIT  = 59
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_seq_if.slave  bus,
    output state_e                   state_o
);
    state_e            state_q;
    logic [OPC_W-1:0]  opc_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              done_q;
    logic              illegal_q;

    logic [INST_W-1:0] inst;
    logic              cls_illegal;
    logic              is_mem_op;
    logic              is_wb_op;

    opc_classify #(
        .OPC_W    (OPC_W),
        .ADD_BIT  (ADD_BIT),
        .AND_BIT  (AND_BIT),
        .MOVL_BIT (MOVL_BIT),
        .MOVS_BIT (MOVS_BIT),
        .JA_BIT   (JA_BIT),
        .CMP_BIT  (CMP_BIT)
    ) u_classify (
        .opc_q_i   (opc_q),
        .inst_o    (inst),
        .illegal_o (cls_illegal)
    );

    assign is_mem_op = inst[I_MOVL] | inst[I_MOVS];
    assign is_wb_op  = inst[I_ADD]  | inst[I_AND];

    // Combinational so the decoder sees stall take effect in the same cycle.
    // TRAP is never IDLE, so ready stays low there until reset.
    assign bus.opc_ready = (state_q == S_IDLE) && !bus.stall;
    assign bus.ctrl      = ctrl_q;
    assign bus.done      = done_q;
    assign bus.illegal   = illegal_q;
    assign state_o       = state_q;

    // Outputs are computed for the state being entered, so ctrl/done always
    // describe the current state. Stall freezes every register, which is also
    // what keeps done high while stalled in a done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            ctrl_q    <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!bus.stall) begin
            ctrl_q <= '0;
            done_q <= 1'b0;
`ifndef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.opc_valid) begin
                        opc_q   <= bus.opc;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (cls_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        illegal_q <= 1'b1;
                        state_q   <= S_TRAP;
`else
                        // NOP: the done/illegal cycle is already IDLE, so a
                        // new opcode may be accepted in it.
                        illegal_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
`endif
                    end else begin
                        ctrl_q  <= exec_word(inst);
                        done_q  <= inst[I_CMP] | inst[I_JA];
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem_op) begin
                        ctrl_q  <= mem_word(inst);
                        done_q  <= inst[I_MOVS];
                        state_q <= S_MEM;
                    end else if (is_wb_op) begin
                        ctrl_q  <= wb_word(inst);
                        done_q  <= 1'b1;
                        state_q <= S_WB;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MEM: begin
                    if (inst[I_MOVL]) begin
                        ctrl_q  <= wb_word(inst);
                        done_q  <= 1'b1;
                        state_q <= S_WB;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_seq.sv
`timescale 1ns/1ps
module tb_multicycle_control_seq;
  import ctrl_pkg::*;

  localparam int OPC_W    = 64;
  localparam int ADD_BIT  = 4;
  localparam int AND_BIT  = 25;
  localparam int MOVL_BIT = 11;
  localparam int MOVS_BIT = 13;
  localparam int JA_BIT   = 14;
  localparam int CMP_BIT  = 59;

  localparam logic [OPC_W-1:0] OP_ADD  = 64'd1 << ADD_BIT;
  localparam logic [OPC_W-1:0] OP_AND  = 64'd1 << AND_BIT;
  localparam logic [OPC_W-1:0] OP_MOVL = 64'd1 << MOVL_BIT;
  localparam logic [OPC_W-1:0] OP_MOVS = 64'd1 << MOVS_BIT;
  localparam logic [OPC_W-1:0] OP_JA   = 64'd1 << JA_BIT;
  localparam logic [OPC_W-1:0] OP_CMP  = 64'd1 << CMP_BIT;

  // expected-cycle word: {ready_when_unstalled, ctrl[6:0], done, illegal}
  localparam int W = 10;
  localparam logic [W-1:0] IDLE_E = {1'b1, 7'b0, 1'b0, 1'b0};
  localparam logic [W-1:0] TRAP_E = {1'b0, 7'b0, 1'b0, 1'b1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_seq_if #(.OPC_W(OPC_W)) bus ();
  state_e dbg_state;

  multicycle_control_seq #(
    .OPC_W(OPC_W), .ADD_BIT(ADD_BIT), .AND_BIT(AND_BIT), .MOVL_BIT(MOVL_BIT),
    .MOVS_BIT(MOVS_BIT), .JA_BIT(JA_BIT), .CMP_BIT(CMP_BIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_cur = IDLE_E;
  logic         trapped = 1'b0;

  function automatic logic [6:0] cw(input logic rw, input logic src, input logic [1:0] op,
                                    input logic mr, input logic mw, input logic m2r);
    return {rw, src, op, mr, mw, m2r};
  endfunction

  function automatic logic [W-1:0] ent(input logic rdy, input logic [6:0] c,
                                       input logic d, input logic il);
    return {rdy, c, d, il};
  endfunction

  // Per-cycle expectations for one accepted opcode, starting with DECODE.
  task automatic push_seq(input logic [OPC_W-1:0] o);
    logic known;
    known = o[ADD_BIT] | o[AND_BIT] | o[MOVL_BIT] | o[MOVS_BIT] | o[JA_BIT] | o[CMP_BIT];
    exp_q.push_back(ent(1'b0, 7'b0, 1'b0, 1'b0));
    if ($countones(o) != 1 || !known) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      trapped = 1'b1;
`else
      exp_q.push_back(ent(1'b1, 7'b0, 1'b1, 1'b1));
`endif
    end else if (o[ADD_BIT] || o[AND_BIT]) begin
      exp_q.push_back(ent(1'b0, cw(1'b0, 1'b0, o[AND_BIT] ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0));
      exp_q.push_back(ent(1'b0, cw(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0));
    end else if (o[MOVL_BIT]) begin
      exp_q.push_back(ent(1'b0, cw(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0));
      exp_q.push_back(ent(1'b0, cw(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0));
      exp_q.push_back(ent(1'b0, cw(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0));
    end else if (o[MOVS_BIT]) begin
      exp_q.push_back(ent(1'b0, cw(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0));
      exp_q.push_back(ent(1'b0, cw(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0));
    end else begin
      exp_q.push_back(ent(1'b0, cw(1'b0, 1'b0, o[JA_BIT] ? 2'b11 : 2'b10, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0));
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      trapped = 1'b0;
      exp_cur = IDLE_E;
    end else if (!bus.stall) begin
      if (bus.opc_valid && exp_cur[9]) push_seq(bus.opc);
      if (exp_q.size() != 0) exp_cur = exp_q.pop_front();
      else                   exp_cur = trapped ? TRAP_E : IDLE_E;
    end
  end

  // compare process: every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc.ctrl",    32'(bus.ctrl),      32'(exp_cur[8:2]));
      check("cyc.done",    32'(bus.done),      32'(exp_cur[1]));
      check("cyc.illegal", 32'(bus.illegal),   32'(exp_cur[0]));
      check("cyc.ready",   32'(bus.opc_ready), 32'(exp_cur[9] & ~bus.stall));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OPC_W-1:0] o);
    tick();
    bus.opc       = o;
    bus.opc_valid = 1'b1;
    @(negedge clk);
    check("accept_ready", 32'(bus.opc_ready), 32'd1);
    tick();
    bus.opc_valid = 1'b0;
    bus.opc       = {$urandom, $urandom};
  endtask

  task automatic expect_cyc(input string name, input logic rdy, input logic [6:0] c,
                            input logic d, input logic il);
    @(negedge clk);
    check({name, ".ctrl"},    32'(bus.ctrl),      32'(c));
    check({name, ".done"},    32'(bus.done),      32'(d));
    check({name, ".illegal"}, 32'(bus.illegal),   32'(il));
    check({name, ".ready"},   32'(bus.opc_ready), 32'(rdy));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.opc       = '0;
    bus.opc_valid = 1'b0;
    bus.stall     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ctrl",    32'(bus.ctrl),      32'd0);
    check("rst.done",    32'(bus.done),      32'd0);
    check("rst.illegal", 32'(bus.illegal),   32'd0);
    check("rst.ready",   32'(bus.opc_ready), 32'd1);
    check("rst.state",   32'(dbg_state),     32'(S_IDLE));
    bus.stall = 1'b1;
    #1 check("rst.ready_stalled", 32'(bus.opc_ready), 32'd0);
    bus.stall = 1'b0;
    #1 rst_n = 1'b1;

    // ADD: DECODE, EXEC, WB(done) -> latency 3
    issue(OP_ADD);
    expect_cyc("add_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("add_exec", 1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("add_wb",   1'b0, 7'b1000000, 1'b1, 1'b0);
    expect_cyc("add_idle", 1'b1, 7'b0000000, 1'b0, 1'b0);

    // MOVL: latency 4
    issue(OP_MOVL);
    expect_cyc("movl_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("movl_exec", 1'b0, 7'b0100000, 1'b0, 1'b0);
    expect_cyc("movl_mem",  1'b0, 7'b0000100, 1'b0, 1'b0);
    expect_cyc("movl_wb",   1'b0, 7'b1000001, 1'b1, 1'b0);
    expect_cyc("movl_idle", 1'b1, 7'b0000000, 1'b0, 1'b0);

    // MOVS: done in MEM
    issue(OP_MOVS);
    expect_cyc("movs_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("movs_exec", 1'b0, 7'b0100000, 1'b0, 1'b0);
    expect_cyc("movs_mem",  1'b0, 7'b0000010, 1'b1, 1'b0);
    expect_cyc("movs_idle", 1'b1, 7'b0000000, 1'b0, 1'b0);

    // AND and JA
    issue(OP_AND);
    expect_cyc("and_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("and_exec", 1'b0, 7'b0001000, 1'b0, 1'b0);
    expect_cyc("and_wb",   1'b0, 7'b1000000, 1'b1, 1'b0);
    issue(OP_JA);
    expect_cyc("ja_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("ja_exec", 1'b0, 7'b0011000, 1'b1, 1'b0);
    expect_cyc("ja_idle", 1'b1, 7'b0000000, 1'b0, 1'b0);

    // CMP with stall held over three edges in EXEC
    issue(OP_CMP);
    expect_cyc("cmp_dec", 1'b0, 7'b0000000, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("cmp_stall", 1'b0, 7'b0010000, 1'b1, 1'b0);
      tick();
    end
    bus.stall = 1'b0;
    expect_cyc("cmp_release", 1'b0, 7'b0010000, 1'b1, 1'b0);
    expect_cyc("cmp_idle",    1'b1, 7'b0000000, 1'b0, 1'b0);

    // stall in IDLE blocks accept, then the pending ADD goes in
    tick();
    bus.stall     = 1'b1;
    bus.opc       = OP_ADD;
    bus.opc_valid = 1'b1;
    expect_cyc("idle_stall", 1'b0, 7'b0000000, 1'b0, 1'b0);
    tick();
    expect_cyc("idle_stall2", 1'b0, 7'b0000000, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b0;
    tick();
    bus.opc_valid = 1'b0;
    expect_cyc("late_add_dec", 1'b0, 7'b0000000, 1'b0, 1'b0);
    repeat (4) tick();

    // back-to-back JA with opc_valid held high
    bus.opc       = OP_JA;
    bus.opc_valid = 1'b1;
    repeat (9) tick();
    bus.opc_valid = 1'b0;
    repeat (4) tick();

    // reset during the MEM cycle of MOVL
    issue(OP_MOVL);
    expect_cyc("rmovl_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("rmovl_exec", 1'b0, 7'b0100000, 1'b0, 1'b0);
    tick();
    check("rmovl_mem.ctrl", 32'(bus.ctrl), 32'h04);
    rst_n = 1'b0;
    #1;
    check("rmovl_rst.ctrl",  32'(bus.ctrl),      32'd0);
    check("rmovl_rst.done",  32'(bus.done),      32'd0);
    check("rmovl_rst.ready", 32'(bus.opc_ready), 32'd1);
    tick();
    check("rmovl_rst2.done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    issue(OP_ADD);
    expect_cyc("radd_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("radd_exec", 1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("radd_wb",   1'b0, 7'b1000000, 1'b1, 1'b0);

    // illegal multi-hot opcode
    issue(OP_ADD | OP_AND);
    expect_cyc("ill_dec", 1'b0, 7'b0000000, 1'b0, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      expect_cyc("trap", 1'b0, 7'b0000000, 1'b0, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("trap_rst.illegal", 32'(bus.illegal),   32'd0);
    check("trap_rst.ready",   32'(bus.opc_ready), 32'd1);
    #1 rst_n = 1'b1;
`else
    expect_cyc("ill_done", 1'b1, 7'b0000000, 1'b1, 1'b1);
    expect_cyc("ill_idle", 1'b1, 7'b0000000, 1'b0, 1'b0);
    // zero opcode, unconfigured single bit, top bit
    issue(64'd0);
    expect_cyc("zero_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("zero_done", 1'b1, 7'b0000000, 1'b1, 1'b1);
    issue(64'd1);
    repeat (3) tick();
    issue(64'd1 << 63);
    repeat (3) tick();
`endif

    // normal operation afterwards
    issue(OP_CMP);
    expect_cyc("post_dec",  1'b0, 7'b0000000, 1'b0, 1'b0);
    expect_cyc("post_exec", 1'b0, 7'b0010000, 1'b1, 1'b0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // time bound
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
